// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 Sobel streaming convolver.
package conv_pkg;

   typedef enum logic [1:0] {
      MODE_SUM = 2'd0,
      MODE_GX  = 2'd1,
      MODE_GY  = 2'd2,
      MODE_THR = 2'd3
   } mode_e;

   // Per-column sideband that travels with the pixels through the pipeline.
   typedef struct packed {
      logic  last;
      mode_e mode;
   } col_tag_t;

   // Sobel smoothing weights; the differencing direction is applied in the math.
   localparam int signed SOBEL_K [3] = '{1, 2, 1};

   function automatic int unsigned min_grad_w(input int unsigned pix_w);
      return pix_w + 3;
   endfunction

endpackage

// File: rtl/conv_window3.sv
// Column capture plus 3-column sliding window with per-row column count.
module conv_window3
   import conv_pkg::*;
#(
   parameter int unsigned PIX_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en_i,
   input  logic                         acc_i,
   input  logic [3*PIX_W-1:0]           col_i,
   input  col_tag_t                     tag_i,
   output logic [2:0][2:0][PIX_W-1:0]   win_o,
   output logic                         valid_o,
   output col_tag_t                     tag_o
);

   logic [2:0][PIX_W-1:0]       cap_q, cap_d;
   col_tag_t                    cap_tag_q, cap_tag_d;
   logic                        cap_vld_q, cap_vld_d;
   logic [2:0][2:0][PIX_W-1:0]  win_q, win_d;
   col_tag_t                    win_tag_q, win_tag_d;
   logic                        win_vld_q, win_vld_d;
   logic [1:0]                  cnt_q, cnt_d;

   // Capture the accepted column, then shift it in as the newest window column.
   always_comb begin
      cap_d     = cap_q;
      cap_tag_d = cap_tag_q;
      cap_vld_d = cap_vld_q;
      win_d     = win_q;
      win_tag_d = win_tag_q;
      win_vld_d = win_vld_q;
      cnt_d     = cnt_q;
      if (en_i) begin
         cap_vld_d = acc_i;
         if (acc_i) begin
            for (int r = 0; r < 3; r++) begin
               cap_d[r] = col_i[(2-r)*PIX_W +: PIX_W];
            end
            cap_tag_d = tag_i;
         end
         win_vld_d = 1'b0;
         if (cap_vld_q) begin
            for (int r = 0; r < 3; r++) begin
               win_d[r][0] = win_q[r][1];
               win_d[r][1] = win_q[r][2];
               win_d[r][2] = cap_q[r];
            end
            win_vld_d = (cnt_q >= 2'd2);
            win_tag_d = cap_tag_q;
            // A row-final column still completes its window, then the next row starts fresh.
            if (cap_tag_q.last) begin
               cnt_d = 2'd0;
            end else if (cnt_q != 2'd3) begin
               cnt_d = cnt_q + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q     <= '0;
         cap_tag_q <= '0;
         cap_vld_q <= 1'b0;
         win_q     <= '0;
         win_tag_q <= '0;
         win_vld_q <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         cap_q     <= cap_d;
         cap_tag_q <= cap_tag_d;
         cap_vld_q <= cap_vld_d;
         win_q     <= win_d;
         win_tag_q <= win_tag_d;
         win_vld_q <= win_vld_d;
         cnt_q     <= cnt_d;
      end
   end

   assign win_o   = win_q;
   assign valid_o = win_vld_q;
   assign tag_o   = win_tag_q;

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Sobel edge detector with valid/ready handshake on both sides.
// Optional threshold output for mode 3 when CONV_THRESH_EN is defined.
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned GRAD_W = min_grad_w(PIX_W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3*PIX_W-1:0]   in_col,
   input  logic                 in_last,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PIX_W-1:0]     out_pix,
   output logic                 out_last
`ifdef CONV_THRESH_EN
   ,
   input  logic [PIX_W-1:0]     thresh
`endif
);

   localparam logic [GRAD_W-1:0] PIX_MAX = GRAD_W'({PIX_W{1'b1}});

   logic                        en;
   logic                        accept;
   col_tag_t                    in_tag;
   logic [2:0][2:0][PIX_W-1:0]  win;
   logic                        win_vld;
   col_tag_t                    win_tag;

   logic signed [GRAD_W-1:0]    gx_c, gy_c;
   logic signed [GRAD_W-1:0]    gx_q, gy_q;
   logic                        s2_vld_q;
   col_tag_t                    s2_tag_q;

   logic [GRAD_W-1:0]           ax_c, ay_c, sum_c, res_c;
   logic [PIX_W-1:0]            pix_c;
   logic                        out_valid_q, out_last_q;
   logic [PIX_W-1:0]            out_pix_q;

   // A held output freezes the whole pipeline.
   assign en       = !(out_valid_q && !out_ready);
   assign in_ready = en && !rst;
   assign accept   = in_valid && in_ready;
   assign in_tag   = '{last: in_last, mode: mode_e'(mode)};

   conv_window3 #(.PIX_W(PIX_W)) u_window (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .acc_i   (accept),
      .col_i   (in_col),
      .tag_i   (in_tag),
      .win_o   (win),
      .valid_o (win_vld),
      .tag_o   (win_tag)
   );

   function automatic logic signed [GRAD_W-1:0] px(input logic [PIX_W-1:0] p);
      return $signed(GRAD_W'(p));
   endfunction

   // Gx differences right minus left column; Gy differences bottom minus top row.
   always_comb begin
      logic signed [GRAD_W-1:0] k;
      k    = '0;
      gx_c = '0;
      gy_c = '0;
      for (int i = 0; i < 3; i++) begin
         k    = GRAD_W'(SOBEL_K[i]);
         gx_c = gx_c + k * (px(win[i][2]) - px(win[i][0]));
         gy_c = gy_c + k * (px(win[2][i]) - px(win[0][i]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld_q <= 1'b0;
         s2_tag_q <= '0;
         gx_q     <= '0;
         gy_q     <= '0;
      end else if (en) begin
         s2_vld_q <= win_vld;
         s2_tag_q <= win_tag;
         gx_q     <= gx_c;
         gy_q     <= gy_c;
      end
   end

   always_comb begin
      ax_c  = gx_q[GRAD_W-1] ? GRAD_W'(-gx_q) : GRAD_W'(gx_q);
      ay_c  = gy_q[GRAD_W-1] ? GRAD_W'(-gy_q) : GRAD_W'(gy_q);
      sum_c = ax_c + ay_c;
      res_c = sum_c;
      case (s2_tag_q.mode)
         MODE_GX:  res_c = ax_c;
         MODE_GY:  res_c = ay_c;
`ifdef CONV_THRESH_EN
         MODE_THR: res_c = (sum_c >= GRAD_W'(thresh)) ? PIX_MAX : '0;
`else
         MODE_THR: res_c = sum_c;
`endif
         default:  res_c = sum_c;
      endcase
      pix_c = (res_c > PIX_MAX) ? {PIX_W{1'b1}} : res_c[PIX_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_last_q  <= 1'b0;
      end else if (en) begin
         out_valid_q <= s2_vld_q;
         if (s2_vld_q) begin
            out_pix_q  <= pix_c;
            out_last_q <= s2_tag_q.last;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;
   assign out_last  = out_last_q;

endmodule
